// File: rtl/adc_meas.sv
// adc_meas: windowed max/min/peak-to-peak and rising mid-code crossing count on one ADC channel.
// Optional crossing hysteresis of +/-HYST codes around mid-code: define ADC_MEAS_HYST_EN.
module adc_meas #(
  parameter int ADC_WIDTH = 12,
  parameter int HYST      = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 param_wen,
  input  logic [31:0]          meas_win_len,
  input  logic [31:0]          meas_ch_sel,
  input  logic                 meas_start,
  input  logic                 adc_valid,
  input  logic [ADC_WIDTH-1:0] adc_data_1,
  input  logic [ADC_WIDTH-1:0] adc_data_2,
  output logic                 meas_busy,
  output logic                 meas_done,
  output logic                 meas_valid,
  output logic [ADC_WIDTH-1:0] meas_max,
  output logic [ADC_WIDTH-1:0] meas_min,
  output logic [ADC_WIDTH-1:0] meas_vpp,
  output logic [31:0]          meas_zc_cnt
);

  // state    | meaning
  // ST_IDLE  | no window since reset, waiting for meas_start
  // ST_FIRST | window open, waiting for the seed sample
  // ST_RUN   | accumulating samples until the window is full
  // ST_DONE  | results published, waiting for the next meas_start
  typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_RUN, ST_DONE} state_t;

  localparam logic [ADC_WIDTH-1:0] MID = {1'b1, {(ADC_WIDTH-1){1'b0}}};
`ifdef ADC_MEAS_HYST_EN
  localparam int BAND = HYST;
`else
  localparam int BAND = 0 * HYST;  // band collapses to a single threshold at mid-code
`endif
  localparam logic [ADC_WIDTH-1:0] TH_HI = MID + ADC_WIDTH'(BAND);
  localparam logic [ADC_WIDTH-1:0] TH_LO = MID - ADC_WIDTH'(BAND);

  state_t               state;
  logic [31:0]          win_len_q;
  logic [31:0]          ch_sel_q;
  logic [31:0]          rem;
  logic [ADC_WIDTH-1:0] run_max;
  logic [ADC_WIDTH-1:0] run_min;
  logic [31:0]          run_zc;
  logic                 prev_above;

  logic [ADC_WIDTH-1:0] samp;
  logic                 samp_above;
  logic                 samp_below;
  logic [ADC_WIDTH-1:0] upd_max;
  logic [ADC_WIDTH-1:0] upd_min;
  logic [31:0]          upd_zc;
  logic                 upd_prev;

  always_comb begin
    samp = MID;
    if (ch_sel_q == 32'd1)      samp = adc_data_1;
    else if (ch_sel_q == 32'd2) samp = adc_data_2;
  end

  assign samp_above = (samp >= TH_HI);
  assign samp_below = (samp <  TH_LO);

  assign upd_max  = (samp > run_max) ? samp : run_max;
  assign upd_min  = (samp < run_min) ? samp : run_min;
  assign upd_zc   = (!prev_above && samp_above && (run_zc != 32'hFFFF_FFFF)) ? run_zc + 32'd1 : run_zc;
  // in-band samples keep the previous side
  assign upd_prev = samp_above ? 1'b1 : (samp_below ? 1'b0 : prev_above);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      win_len_q   <= '0;
      ch_sel_q    <= '0;
      rem         <= '0;
      run_max     <= '0;
      run_min     <= '0;
      run_zc      <= '0;
      prev_above  <= 1'b0;
      meas_busy   <= 1'b0;
      meas_done   <= 1'b0;
      meas_valid  <= 1'b0;
      meas_max    <= '0;
      meas_min    <= '0;
      meas_vpp    <= '0;
      meas_zc_cnt <= '0;
    end else begin
      meas_done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (param_wen) begin
            win_len_q <= meas_win_len;
            ch_sel_q  <= meas_ch_sel;
          end
          if (meas_start) begin
            state      <= ST_FIRST;
            meas_valid <= 1'b0;
            meas_busy  <= 1'b1;
            rem        <= '0;
          end
        end
        ST_FIRST: begin
          if (adc_valid) begin
            run_max    <= samp;
            run_min    <= samp;
            run_zc     <= '0;
            prev_above <= samp_above;
            if (win_len_q <= 32'd1) begin
              state       <= ST_DONE;
              meas_busy   <= 1'b0;
              meas_done   <= 1'b1;
              meas_valid  <= 1'b1;
              meas_max    <= samp;
              meas_min    <= samp;
              meas_vpp    <= '0;
              meas_zc_cnt <= '0;
            end else begin
              rem   <= win_len_q - 32'd1;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (adc_valid) begin
            run_max    <= upd_max;
            run_min    <= upd_min;
            run_zc     <= upd_zc;
            prev_above <= upd_prev;
            rem        <= rem - 32'd1;
            if (rem == 32'd1) begin
              state       <= ST_DONE;
              meas_busy   <= 1'b0;
              meas_done   <= 1'b1;
              meas_valid  <= 1'b1;
              meas_max    <= upd_max;
              meas_min    <= upd_min;
              meas_vpp    <= upd_max - upd_min;
              meas_zc_cnt <= upd_zc;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_meas.sv
// Randomized scoreboard bench for adc_meas: expected window results are queued by the
// driver and compared by an independent monitor on every meas_done pulse.
module tb_adc_meas;

  localparam int HYST = 16;
  localparam logic [11:0] MID = 12'h800;

  logic        clk;
  logic        rstn;
  logic        param_wen;
  logic [31:0] meas_win_len;
  logic [31:0] meas_ch_sel;
  logic        meas_start;
  logic        adc_valid;
  logic [11:0] adc_data_1;
  logic [11:0] adc_data_2;
  logic        meas_busy;
  logic        meas_done;
  logic        meas_valid;
  logic [11:0] meas_max;
  logic [11:0] meas_min;
  logic [11:0] meas_vpp;
  logic [31:0] meas_zc_cnt;

  adc_meas #(.ADC_WIDTH(12), .HYST(HYST)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .param_wen    (param_wen),
    .meas_win_len (meas_win_len),
    .meas_ch_sel  (meas_ch_sel),
    .meas_start   (meas_start),
    .adc_valid    (adc_valid),
    .adc_data_1   (adc_data_1),
    .adc_data_2   (adc_data_2),
    .meas_busy    (meas_busy),
    .meas_done    (meas_done),
    .meas_valid   (meas_valid),
    .meas_max     (meas_max),
    .meas_min     (meas_min),
    .meas_vpp     (meas_vpp),
    .meas_zc_cnt  (meas_zc_cnt)
  );

  typedef struct {
    logic [11:0] mx;
    logic [11:0] mn;
    logic [11:0] vpp;
    logic [31:0] zc;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [11:0] d1[$];
  logic [11:0] d2[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // 1 = above, 0 = below, 2 = inside the hysteresis band
  function automatic int side(input logic [11:0] x);
    int v;
    v = int'({20'd0, x});
`ifdef ADC_MEAS_HYST_EN
    if (v >= 2048 + HYST) return 1;
    if (v < 2048 - HYST)  return 0;
    return 2;
`else
    return (v >= 2048) ? 1 : 0;
`endif
  endfunction

  function automatic exp_t model(input logic [11:0] s[$]);
    exp_t r;
    bit   prev;
    int   sd;
    r.mx = s[0];
    r.mn = s[0];
    r.zc = 0;
    prev = (side(s[0]) == 1);
    for (int i = 1; i < s.size(); i++) begin
      if (s[i] > r.mx) r.mx = s[i];
      if (s[i] < r.mn) r.mn = s[i];
      sd = side(s[i]);
      if (sd == 1 && !prev && r.zc != 32'hFFFF_FFFF) r.zc = r.zc + 1;
      if (sd != 2) prev = (sd == 1);
    end
    r.vpp = r.mx - r.mn;
    r.cyc = 0;
    return r;
  endfunction

  task automatic fill_rand(input int n);
    d1 = {};
    d2 = {};
    for (int i = 0; i < n; i++) begin
      d1.push_back(12'($urandom));
      d2.push_back(12'($urandom));
    end
  endtask

  task automatic do_window(input logic [31:0] ch, input logic [31:0] len, input int stall_pct,
                           input bit poke_mid, input bit start_at_end);
    int          n;
    exp_t        e;
    logic [11:0] sel[$];
    n = (len == 0) ? 1 : int'(len);
    sel = {};
    for (int i = 0; i < n; i++)
      sel.push_back((ch == 32'd1) ? d1[i] : (ch == 32'd2) ? d2[i] : MID);
    e = model(sel);
    @(negedge clk);
    param_wen = 1'b1; meas_win_len = len; meas_ch_sel = ch;
    @(negedge clk);
    param_wen = 1'b0; meas_start = 1'b1;
    @(negedge clk);
    meas_start = 1'b0;
    chk("busy_after_start", 32'(meas_busy), 32'd1);
    chk("valid_cleared_by_start", 32'(meas_valid), 32'd0);
    for (int i = 0; i < n; ) begin
      if ($urandom_range(0, 99) < stall_pct) begin
        adc_valid = 1'b0;
        adc_data_1 = 12'($urandom);
        adc_data_2 = 12'($urandom);
      end else begin
        adc_valid = 1'b1;
        adc_data_1 = d1[i];
        adc_data_2 = d2[i];
        if (poke_mid && i == n / 2) begin
          param_wen = 1'b1; meas_win_len = 32'd4;
          meas_ch_sel = (ch == 32'd1) ? 32'd2 : 32'd1;
          meas_start = 1'b1;
        end
        if (start_at_end && i == n - 1) meas_start = 1'b1;
        if (i == n - 1) begin
          e.cyc = cyc + 1;
          exp_q.push_back(e);
        end
        i++;
      end
      @(negedge clk);
      param_wen = 1'b0;
      meas_start = 1'b0;
    end
    adc_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_after_done", 32'(meas_busy), 32'd0);
    chk("valid_sticky", 32'(meas_valid), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(meas_busy),  32'd0);
    chk({tag, "_done"},  32'(meas_done),  32'd0);
    chk({tag, "_valid"}, 32'(meas_valid), 32'd0);
    chk({tag, "_max"},   32'(meas_max),   32'd0);
    chk({tag, "_min"},   32'(meas_min),   32'd0);
    chk({tag, "_vpp"},   32'(meas_vpp),   32'd0);
    chk({tag, "_zc"},    meas_zc_cnt,     32'd0);
  endtask

  always @(negedge clk) begin
    if (rstn && meas_done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'(meas_done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("max", 32'(meas_max), 32'(mon_e.mx));
        chk("min", 32'(meas_min), 32'(mon_e.mn));
        chk("vpp", 32'(meas_vpp), 32'(mon_e.vpp));
        chk("zc", meas_zc_cnt, mon_e.zc);
        chk("done_latency_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("valid_with_done", 32'(meas_valid), 32'd1);
        chk("busy_low_with_done", 32'(meas_busy), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ch;
    int          r;
    rstn = 1'b0; param_wen = 1'b0; meas_win_len = '0; meas_ch_sel = '0;
    meas_start = 1'b0; adc_valid = 1'b0; adc_data_1 = '0; adc_data_2 = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk_all_zero("after_release");

    // zero window length behaves as one sample; channel 0 is invalid
    fill_rand(1);
    do_window(32'd0, 32'd0, 0, 1'b0, 1'b0);

    d1 = {12'h800, 12'h900, 12'h700, 12'hA00, 12'h600, 12'h800, 12'h7FF, 12'h801};
    d2 = {12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666, 12'h777, 12'h888};
    do_window(32'd1, 32'd8, 0, 1'b0, 1'b0);

    d1 = {};
    d2 = {};
    for (int i = 0; i < 1000; i++) begin
      d1.push_back(12'($urandom));
      d2.push_back(((i / 50) % 2 == 0) ? 12'h400 : 12'hC00);
    end
    do_window(32'd2, 32'd1000, 0, 1'b0, 1'b0);

    fill_rand(16);
    do_window(32'd3, 32'd16, 25, 1'b0, 1'b0);

    fill_rand(12);
    do_window(32'd1, 32'd12, 20, 1'b1, 1'b0);

    fill_rand(6);
    do_window(32'd2, 32'd6, 0, 1'b0, 1'b1);

    d1 = {};
    d2 = {};
    for (int i = 0; i < 20; i++) begin
      d1.push_back((i % 2 == 0) ? 12'h7F8 : 12'h808);
      d2.push_back((i % 2 == 0) ? 12'h700 : 12'h900);
    end
    do_window(32'd1, 32'd20, 10, 1'b0, 1'b0);
    do_window(32'd2, 32'd20, 10, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 4);
      ch = (r < 4) ? 32'(r) : $urandom;
      r = $urandom_range(0, 40);
      fill_rand((r == 0) ? 1 : r);
      do_window(ch, 32'(r), 30, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of a 100-sample window
    fill_rand(100);
    @(negedge clk);
    param_wen = 1'b1; meas_win_len = 32'd100; meas_ch_sel = 32'd1;
    @(negedge clk);
    param_wen = 1'b0; meas_start = 1'b1;
    @(negedge clk);
    meas_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      adc_valid = 1'b1;
      adc_data_1 = d1[i];
      @(negedge clk);
    end
    chk("busy_before_abort", 32'(meas_busy), 32'd1);
    #2 rstn = 1'b0;
    #1 chk_all_zero("async_reset");
    adc_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    fill_rand(100);
    do_window(32'd1, 32'd100, 20, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
